// File: rtl/audio_stream_framer_pkg.sv
// audio_stream_framer_pkg
// Widths and a helper that maps a bit-depth code to the number of payload
// bytes making up one stereo frame.

`include "definitions.svh"

package audio_stream_framer_pkg;

  localparam int LEN_W       = 16;  // packet length field width
  localparam int FRAME_CNT_W = 4;   // holds frame sizes up to 8

  // Stereo frame size in bytes: two samples of 2, 3 or 4 bytes.
  // DoP travels in 24-bit containers, so it shares the 24-bit size.
  function automatic logic [FRAME_CNT_W-1:0] frame_bytes(input logic [1:0] depth);
    logic [FRAME_CNT_W-1:0] size;
    case (depth)
      `BIT_DEPTH_16: size = 4'd4;
      `BIT_DEPTH_32: size = 4'd8;
      default:       size = 4'd6;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/definitions.svh
// definitions.svh
// Shared encodings for the audio streaming path: bit-depth and sample-rate
// codes, the stream sync byte, and the bit positions of the fields in the
// packet cfg byte. Include-guarded so several files can pull it in.

`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH

// Bit-depth encodings (2 bits)
`define BIT_DEPTH_16        2'd0
`define BIT_DEPTH_24        2'd1
`define BIT_DEPTH_32        2'd2
`define BIT_DEPTH_DOP       2'd3

// Sample-rate encodings (3 bits)
`define SAMPLE_RATE_44K1    3'd0
`define SAMPLE_RATE_48K     3'd1
`define SAMPLE_RATE_88K2    3'd2
`define SAMPLE_RATE_96K     3'd3
`define SAMPLE_RATE_176K4   3'd4
`define SAMPLE_RATE_192K    3'd5
`define SAMPLE_RATE_352K8   3'd6
`define SAMPLE_RATE_384K    3'd7

// Stream packet framing
`define STREAM_SYNC_BYTE    8'hA5

// cfg byte layout: {sample_rate[7:5], bit_depth[4:3], reserved[2:0]}
`define CFG_RATE_MSB        7
`define CFG_RATE_LSB        5
`define CFG_DEPTH_MSB       4
`define CFG_DEPTH_LSB       3

`endif

// File: rtl/audio_stream_framer.sv
// audio_stream_framer
// Parses the byte stream from the FT2232H FIFO side into packets
// (0xA5, cfg, LEN_HI, LEN_LO, LEN payload bytes) and forwards the payload
// to the tx_i2s output FIFO. A new packet's configuration is only applied
// once the (synchronized) output streaming flag is low, so the rate/depth
// never change under a running I2S stream.
//
// Ports:
//   clk_i, reset_i                 clock / asynchronous active-high reset
//   in_data_i, in_valid_i,
//   in_ready_o                     input byte stream (valid/ready handshake)
//   wr_output_FIFO_en_o/_data_o    write port of the tx_i2s output FIFO
//   wr_output_FIFO_afull_i         output FIFO almost full (stalls payload)
//   output_streaming_i             tx_i2s streaming flag (other clock domain)
//   sample_rate_o, bit_depth_o     config latched for the current packet
//   frame_err_o                    sticky: payload ended mid-frame
//   busy_o                         high whenever not hunting for sync
//
// Optional feature macro STREAM_STATS_EN adds stat_bytes_o (32-bit, wraps),
// stat_packets_o (16-bit) and stat_frame_errs_o (8-bit, saturating).

`include "definitions.svh"

module audio_stream_framer
  import audio_stream_framer_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       wr_output_FIFO_en_o,
  output logic [7:0] wr_output_FIFO_data_o,
  input  logic       wr_output_FIFO_afull_i,
  input  logic       output_streaming_i,
  output logic [2:0] sample_rate_o,
  output logic [1:0] bit_depth_o,
  output logic       frame_err_o,
  output logic       busy_o
`ifdef STREAM_STATS_EN
  ,
  output logic [31:0] stat_bytes_o,
  output logic [15:0] stat_packets_o,
  output logic [7:0]  stat_frame_errs_o
`endif
);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_CFG,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WAIT_IDLE,
    ST_PAYLOAD
  } state_t;

  state_t                 state_reg;
  logic                   streaming_meta_reg;
  logic                   streaming_sync_reg;
  logic [2:0]             pend_rate_reg;
  logic [1:0]             pend_depth_reg;
  logic [7:0]             len_hi_reg;
  logic [LEN_W-1:0]       remaining_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [FRAME_CNT_W-1:0] frame_size_reg;
  logic [2:0]             sample_rate_reg;
  logic [1:0]             bit_depth_reg;
  logic                   frame_err_reg;
  logic                   wr_en_reg;
  logic [7:0]             wr_data_reg;

  logic                   accept;
  logic                   payload_accept;
  logic                   last_byte;
  logic [FRAME_CNT_W-1:0] frame_cnt_inc;
  logic [FRAME_CNT_W-1:0] frame_cnt_next;
  logic                   short_frame;

  // Ready is a pure decode of the state so the upstream handshake sees
  // afull in the same cycle; WAIT_IDLE holds the stream while config waits.
  always_comb begin
    in_ready_o = 1'b1;
    case (state_reg)
      ST_WAIT_IDLE: in_ready_o = 1'b0;
      ST_PAYLOAD:   in_ready_o = ~wr_output_FIFO_afull_i;
      default:      in_ready_o = 1'b1;
    endcase
  end

  assign accept         = in_valid_i & in_ready_o;
  assign payload_accept = accept & (state_reg == ST_PAYLOAD);
  assign last_byte      = (remaining_reg == 16'd1);
  assign frame_cnt_inc  = frame_cnt_reg + 4'd1;
  assign frame_cnt_next = (frame_cnt_inc == frame_size_reg) ? '0 : frame_cnt_inc;
  assign short_frame    = (frame_cnt_next != '0);

  assign busy_o                = (state_reg != ST_SYNC);
  assign wr_output_FIFO_en_o   = wr_en_reg;
  assign wr_output_FIFO_data_o = wr_data_reg;
  assign sample_rate_o         = sample_rate_reg;
  assign bit_depth_o           = bit_depth_reg;
  assign frame_err_o           = frame_err_reg;

  // Two-flop synchronizer for the streaming flag from the I2S domain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      streaming_meta_reg <= 1'b0;
      streaming_sync_reg <= 1'b0;
    end else begin
      streaming_meta_reg <= output_streaming_i;
      streaming_sync_reg <= streaming_meta_reg;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= ST_SYNC;
      pend_rate_reg   <= 3'd0;
      pend_depth_reg  <= `BIT_DEPTH_16;
      len_hi_reg      <= 8'd0;
      remaining_reg   <= '0;
      frame_cnt_reg   <= '0;
      frame_size_reg  <= '0;
      sample_rate_reg <= 3'd0;
      bit_depth_reg   <= `BIT_DEPTH_16;
      frame_err_reg   <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_data_reg     <= 8'd0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_SYNC: begin
          if (accept && in_data_i == `STREAM_SYNC_BYTE) state_reg <= ST_CFG;
        end
        ST_CFG: begin
          if (accept) begin
            // Reserved bits [2:0] are simply not stored.
            pend_rate_reg  <= in_data_i[`CFG_RATE_MSB:`CFG_RATE_LSB];
            pend_depth_reg <= in_data_i[`CFG_DEPTH_MSB:`CFG_DEPTH_LSB];
            state_reg      <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_reg <= in_data_i;
            state_reg  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if ({len_hi_reg, in_data_i} == 16'd0) begin
              state_reg <= ST_SYNC;  // empty packet: nothing is applied
            end else begin
              remaining_reg <= {len_hi_reg, in_data_i};
              state_reg     <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (!streaming_sync_reg) begin
            sample_rate_reg <= pend_rate_reg;
            bit_depth_reg   <= pend_depth_reg;
            frame_err_reg   <= 1'b0;
            frame_cnt_reg   <= '0;
            frame_size_reg  <= frame_bytes(pend_depth_reg);
            state_reg       <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (payload_accept) begin
            wr_en_reg     <= 1'b1;
            wr_data_reg   <= in_data_i;
            remaining_reg <= remaining_reg - 16'd1;
            frame_cnt_reg <= frame_cnt_next;
            if (last_byte) begin
              state_reg <= ST_SYNC;
              if (short_frame) frame_err_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_SYNC;
      endcase
    end
  end

`ifdef STREAM_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_bytes_o      <= 32'd0;
      stat_packets_o    <= 16'd0;
      stat_frame_errs_o <= 8'd0;
    end else if (payload_accept) begin
      stat_bytes_o <= stat_bytes_o + 32'd1;
      if (last_byte) begin
        stat_packets_o <= stat_packets_o + 16'd1;
        if (short_frame && stat_frame_errs_o != 8'hFF)
          stat_frame_errs_o <= stat_frame_errs_o + 8'd1;
      end
    end
  end
`endif

endmodule
